// File: rtl/video_pkg.sv
// Shared raster constants and NMI state encoding for the video timing block.
// The top exposes these as parameter defaults so a reduced raster can be built.
package video_pkg;

  localparam int H_TOTAL     = 768;
  localparam int V_TOTAL     = 264;
  localparam int V_ACT_START = 16;
  localparam int V_ACT_END   = 240;
  localparam int HSYNC_START = 576;
  localparam int HSYNC_END   = 640;
  localparam int VSYNC_START = 248;
  localparam int VSYNC_END   = 252;

  localparam int H_W = 10;
  localparam int V_W = 9;

  typedef enum logic {
    IDLE   = 1'b0,
    ASSERT = 1'b1
  } nmi_state_t;

endpackage

// File: rtl/raster_counter.sv
// Wrap counter 0..TOTAL-1 with an enable; tc flags the last count so the
// next stage can advance in the same cycle this one wraps.
module raster_counter #(
  parameter int W     = 10,
  parameter int TOTAL = 768
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/vidtiming.sv
// Raster timing generator: H/V counters, blanking and sync, CPU-written flip
// and NMI-mask latches, frame-aligned flip staging and the vblank NMI FSM.
module vidtiming
  import video_pkg::*;
#(
  parameter int H_TOTAL     = video_pkg::H_TOTAL,
  parameter int V_TOTAL     = video_pkg::V_TOTAL,
  parameter int V_ACT_START = video_pkg::V_ACT_START,
  parameter int V_ACT_END   = video_pkg::V_ACT_END,
  parameter int HSYNC_START = video_pkg::HSYNC_START,
  parameter int HSYNC_END   = video_pkg::HSYNC_END,
  parameter int VSYNC_START = video_pkg::VSYNC_START,
  parameter int VSYNC_END   = video_pkg::VSYNC_END
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wrn,
  input  logic       ctrl_ena,
  input  logic       addr,
  input  logic       din,
  output logic [9:0] htiming,
  output logic [7:0] vtiming,
  output logic [7:0] vtiming_f,
  output logic       cmpblk,
  output logic       vblank,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       flip_ena,
  output logic       nmi_n,
  output nmi_state_t nmi_state
);

  localparam logic [9:0] HS_S    = 10'(HSYNC_START);
  localparam logic [9:0] HS_E    = 10'(HSYNC_END);
  localparam logic [8:0] V_AS    = 9'(V_ACT_START);
  localparam logic [8:0] V_AE    = 9'(V_ACT_END);
  localparam logic [8:0] V_ENTRY = 9'(V_ACT_END - 1);
  localparam logic [8:0] VS_S    = 9'(VSYNC_START);
  localparam logic [8:0] VS_E    = 9'(VSYNC_END);

  logic [9:0] hcnt;
  logic [8:0] vcnt;
  logic       h_tc;
  logic       v_tc;

  raster_counter #(.W(H_W), .TOTAL(H_TOTAL)) u_hcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .cnt   (hcnt),
    .tc    (h_tc)
  );

  raster_counter #(.W(V_W), .TOTAL(V_TOTAL)) u_vcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (h_tc),
    .cnt   (vcnt),
    .tc    (v_tc)
  );

  // CPU write: one latch update per clk while ctrl_ena is high and wrn is low.
  logic wr;
  logic wr_flip;
  logic wr_mask;
  logic frame_wrap;
  logic vbl_entry;

  assign wr         = ctrl_ena & ~wrn;
  assign wr_flip    = wr & ~addr;
  assign wr_mask    = wr & addr;
  assign frame_wrap = h_tc & v_tc;
  // True in the last cycle before vcnt reaches V_ACT_END.
  assign vbl_entry  = h_tc & (vcnt == V_ENTRY);

  logic flip_pend;
  logic nmi_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flip_pend <= 1'b0;
      nmi_mask  <= 1'b0;
      flip_ena  <= 1'b0;
    end else begin
      if (wr_flip) flip_pend <= din;
      if (wr_mask) nmi_mask  <= din;
      if (frame_wrap) flip_ena <= flip_pend;
    end
  end

  nmi_state_t state_q;
  nmi_state_t state_d;
  logic       mask_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A write landing in the entry cycle decides the mask, so write-0 wins.
  always_comb begin
    state_d  = state_q;
    mask_eff = wr_mask ? din : nmi_mask;
    case (state_q)
      IDLE:    if (vbl_entry && mask_eff) state_d = ASSERT;
      ASSERT:  if (wr_mask && !din)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic hblank;

  assign hblank    = hcnt[9];
  assign htiming   = hcnt;
  assign vtiming   = vcnt[7:0];
  assign vtiming_f = vcnt[7:0] ^ {8{flip_ena}};
  assign vblank    = (vcnt < V_AS) | (vcnt >= V_AE);
  assign cmpblk    = hblank | vblank;
  assign hsync_n   = ~((hcnt >= HS_S) & (hcnt < HS_E));
  assign vsync_n   = ~((vcnt >= VS_S) & (vcnt < VS_E));
  assign nmi_n     = (state_q == IDLE);
  assign nmi_state = state_q;

endmodule

// File: tb/tb_vidtiming.sv
// Bench for vidtiming on a reduced raster: every cycle is compared against a
// count-based reference model while directed steps exercise NMI, flip and reset.
module tb_vidtiming;
  import video_pkg::*;

  localparam int BH    = 544;
  localparam int BV    = 24;
  localparam int BVS   = 2;
  localparam int BVE   = 18;
  localparam int BHS   = 520;
  localparam int BHE   = 536;
  localparam int BVSS  = 20;
  localparam int BVSE  = 24;
  localparam int FRAME = BH * BV;

  logic       clk;
  logic       rst_n;
  logic       wrn;
  logic       ctrl_ena;
  logic       addr;
  logic       din;
  logic [9:0] htiming;
  logic [7:0] vtiming;
  logic [7:0] vtiming_f;
  logic       cmpblk;
  logic       vblank;
  logic       hsync_n;
  logic       vsync_n;
  logic       flip_ena;
  logic       nmi_n;
  nmi_state_t nmi_state;

  vidtiming #(
    .H_TOTAL(BH), .V_TOTAL(BV), .V_ACT_START(BVS), .V_ACT_END(BVE),
    .HSYNC_START(BHS), .HSYNC_END(BHE), .VSYNC_START(BVSS), .VSYNC_END(BVSE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wrn       (wrn),
    .ctrl_ena  (ctrl_ena),
    .addr      (addr),
    .din       (din),
    .htiming   (htiming),
    .vtiming   (vtiming),
    .vtiming_f (vtiming_f),
    .cmpblk    (cmpblk),
    .vblank    (vblank),
    .hsync_n   (hsync_n),
    .vsync_n   (vsync_n),
    .flip_ena  (flip_ena),
    .nmi_n     (nmi_n),
    .nmi_state (nmi_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: t is clocks since reset release; counts follow from t.
  int t      = 0;
  bit m_mask = 0;
  bit m_pend = 0;
  bit m_flip = 0;
  bit m_nmi  = 0;

  int cyc        = 0;
  int last_start = 0;
  bit have_start = 0;
  int hs_run     = 0;
  int hs_start   = 0;
  int vs_run     = 0;
  int vs_start   = 0;

  function automatic int cur_h();
    return t % BH;
  endfunction

  function automatic int cur_v();
    return (t / BH) % BV;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      if (n_fail <= 30)
        $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_edge();
    bit wr;
    bit eff;
    int nh;
    int nv;
    wr  = ctrl_ena && !wrn;
    nh  = (t + 1) % BH;
    nv  = ((t + 1) / BH) % BV;
    eff = (wr && addr) ? din : m_mask;
    if (wr && addr && !din)                  m_nmi = 0;
    else if (!m_nmi && nh == 0 && nv == BVE && eff) m_nmi = 1;
    if (nh == 0 && nv == 0) m_flip = m_pend;
    if (wr && !addr) m_pend = din;
    if (wr && addr)  m_mask = din;
    t = t + 1;
  endtask

  task automatic check_all();
    int h;
    int v;
    bit hb;
    bit vb;
    h  = cur_h();
    v  = cur_v();
    hb = (h >= 512);
    vb = (v < BVS) || (v >= BVE);
    chk("htiming",   htiming,   h);
    chk("vtiming",   vtiming,   v & 255);
    chk("vtiming_f", vtiming_f, (v ^ (m_flip ? 255 : 0)) & 255);
    chk("vblank",    vblank,    vb);
    chk("cmpblk",    cmpblk,    hb || vb);
    chk("hsync_n",   hsync_n,   !(h >= BHS && h < BHE));
    chk("vsync_n",   vsync_n,   !(v >= BVSS && v < BVSE));
    chk("flip_ena",  flip_ena,  m_flip);
    chk("nmi_n",     nmi_n,     !m_nmi);
    chk("nmi_state", nmi_state, m_nmi ? ASSERT : IDLE);
  endtask

  task automatic observe_runs();
    if (!hsync_n) begin
      if (hs_run == 0) hs_start = htiming;
      hs_run++;
    end else if (hs_run != 0) begin
      chk("hsync_len", hs_run, BHE - BHS);
      chk("hsync_start", hs_start, BHS);
      hs_run = 0;
    end
    if (!vsync_n) begin
      if (vs_run == 0) vs_start = vtiming;
      vs_run++;
    end else if (vs_run != 0) begin
      chk("vsync_len", vs_run, (BVSE - BVSS) * BH);
      chk("vsync_start", vs_start, BVSS);
      vs_run = 0;
    end
    if (htiming == 0 && vtiming == 0) begin
      if (have_start) chk("frame_len", cyc - last_start, FRAME);
      last_start = cyc;
      have_start = 1;
    end
  endtask

  // Non-writing bus noise: never ctrl_ena and wrn active together.
  task automatic idle_inputs();
    case ($urandom_range(0, 2))
      0:       begin ctrl_ena = 1'b0; wrn = 1'b1; end
      1:       begin ctrl_ena = 1'b1; wrn = 1'b1; end
      default: begin ctrl_ena = 1'b0; wrn = 1'b0; end
    endcase
    addr = 1'($urandom_range(0, 1));
    din  = 1'($urandom_range(0, 1));
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_all();
    observe_runs();
    idle_inputs();
  endtask

  task automatic cpu_write(input logic a, input logic d);
    ctrl_ena = 1'b1;
    wrn      = 1'b0;
    addr     = a;
    din      = d;
    step();
  endtask

  task automatic run_to(input int v, input int h);
    for (int i = 0; i < 2 * FRAME && !(cur_v() == v && cur_h() == h); i++) step();
    if (!(cur_v() == v && cur_h() == h)) begin
      n_cmp++;
      n_fail++;
      $error("FAIL run_to: observed v=%0d h=%0d expected v=%0d h=%0d", cur_v(), cur_h(), v, h);
    end
  endtask

  task automatic model_reset();
    t = 0; m_mask = 0; m_pend = 0; m_flip = 0; m_nmi = 0;
    cyc = 0; last_start = 0; have_start = 1;
    hs_run = 0; vs_run = 0;
  endtask

  initial begin
    rst_n = 1'b0; ctrl_ena = 1'b0; wrn = 1'b1; addr = 1'b0; din = 1'b0;
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 0: first line, flip staging, NMI raise / acknowledge / late re-arm
    run_to(1, 0);
    chk("line0_end_vtiming", vtiming, 1);
    run_to(BVS, 0);
    chk("active_cmpblk", cmpblk, 0);
    run_to(4, $urandom_range(0, BH - 1));
    cpu_write(1'b0, 1'b1);
    run_to(6, $urandom_range(0, BH - 1));
    cpu_write(1'b1, 1'b1);
    run_to(BVE - 1, BH - 1);
    chk("nmi_before_entry", nmi_n, 1);
    step();
    chk("nmi_at_entry", nmi_n, 0);
    chk("vblank_at_entry", vblank, 1);
    run_to(19, $urandom_range(0, BH - 1));
    cpu_write(1'b1, 1'b0);
    chk("nmi_ack", nmi_n, 1);
    run_to(20, $urandom_range(0, BH - 1));
    cpu_write(1'b1, 1'b1);
    run_to(BV - 1, BH - 1);
    chk("flip_hold", flip_ena, 0);
    chk("vtiming_f_hold", vtiming_f, BV - 1);
    step();
    chk("flip_applied", flip_ena, 1);
    chk("vtiming_f_wrap", vtiming_f, 8'hFF);

    // Frame 1: re-armed mask raises the next NMI, then ack and arm again
    run_to(BVE, 0);
    chk("nmi_frame1", nmi_n, 0);
    run_to(19, $urandom_range(0, BH - 1));
    cpu_write(1'b1, 1'b0);
    run_to(21, $urandom_range(0, BH - 1));
    cpu_write(1'b1, 1'b1);

    // Frame 2: write 0 lands on the entry edge, then a late set in vblank
    run_to(BVE - 1, BH - 1);
    cpu_write(1'b1, 1'b0);
    chk("nmi_simul_write", nmi_n, 1);
    chk("simul_vtiming", vtiming, BVE);
    run_to(19, $urandom_range(0, BH - 1));
    cpu_write(1'b1, 1'b1);
    run_to(BV - 1, BH - 1);

    // Frame 3: NMI asserted, then asynchronous reset mid-vsync
    run_to(BVE, 0);
    chk("nmi_frame3", nmi_n, 0);
    run_to(20, $urandom_range(0, BH - 2));
    rst_n = 1'b0;
    #1;
    chk("rst_nmi_n", nmi_n, 1);
    chk("rst_htiming", htiming, 0);
    chk("rst_flip_ena", flip_ena, 0);
    chk("rst_vtiming", vtiming, 0);
    chk("rst_vblank", vblank, 1);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check_all();
    rst_n = 1'b1;
    run_to(3, $urandom_range(0, BH - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
